irrigation_scheduler: RTL

IRRIGATION_SCHEDULER -- requirements
Module: irrigation_scheduler

---
 rtl/irrigation_scheduler.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/irrigation_scheduler.sv
// Irrigation scheduler: scans zones on request, opens one valve at a time,
// settles, pumps until the zone reads wet or a per-visit timeout trips.
// Ports: clk/rst_n (async active-low), en, sample, ms/ts/ct sensor inputs,
// fault_clr; outputs valve, pump, fault, alarm, busy, zone.
module irrigation_scheduler #(
  parameter int N_ZONES  = 4,
  parameter int SW       = 4,
  parameter int SETTLE   = 4,
  parameter int MAX_ON   = 16,
  parameter int HYST     = 2,
  parameter int HOT_T    = 12,
  parameter int HEAT_ADD = 2,
  localparam int ZW      = $clog2(N_ZONES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  sample,
  input  logic [N_ZONES*SW-1:0] ms,
  input  logic [SW-1:0]         ts,
  input  logic [N_ZONES*2-1:0]  ct,
  input  logic                  fault_clr,
  output logic [N_ZONES-1:0]    valve,
  output logic                  pump,
  output logic [N_ZONES-1:0]    fault,
  output logic                  alarm,
  output logic                  busy,
  output logic [ZW-1:0]         zone
);

  localparam int CMAX = (MAX_ON > SETTLE) ? MAX_ON : SETTLE;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    SETTLE_S = 3'd2,
    WATER  = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic                stop;     // visit aborted by en=0: return to IDLE after DRAIN

  logic [SW-1:0]       ms_z;
  logic [1:0]          ct_z;
  logic [SW:0]         thr_raw;
  logic [SW:0]         wet_raw;
  logic [SW-1:0]       thr;
  logic [SW-1:0]       wet;
  logic                dry;
  logic                is_wet;
  logic                last;
  logic                timeout;
  logic [N_ZONES-1:0]  zone_oh;
  logic [N_ZONES-1:0]  fault_nxt;

  // Live (unlatched) evaluation of the zone under the pointer.
  always_comb begin
    ms_z    = ms[zone*SW +: SW];
    ct_z    = ct[zone*2 +: 2];
    thr_raw = ((SW+1)'(ct_z) + (SW+1)'(2)) << (SW-3);
    if (32'(ts) >= HOT_T)
      thr_raw = thr_raw + (SW+1)'(HEAT_ADD);
    // Anything with the carry bit set is above 2^SW-1: saturate.
    thr     = thr_raw[SW] ? '1 : thr_raw[SW-1:0];
    wet_raw = {1'b0, thr} + (SW+1)'(HYST);
    wet     = wet_raw[SW] ? '1 : wet_raw[SW-1:0];
    dry     = (ms_z < thr);
    is_wet  = (ms_z >= wet);
    last    = (zone == ZW'(N_ZONES-1));
    zone_oh = {{(N_ZONES-1){1'b0}}, 1'b1} << zone;
    // en=0 takes priority over a timeout on the same cycle.
    timeout = (state == WATER) && en && !is_wet && (cnt == CW'(MAX_ON-1));
    // A timeout beats a simultaneous clear for its own zone.
    fault_nxt = (fault_clr ? '0 : fault) | (timeout ? zone_oh : '0);
  end

  assign alarm = |fault;

  // valve/pump/busy are set on the same edge as the state they decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      zone  <= '0;
      cnt   <= '0;
      stop  <= 1'b0;
      valve <= '0;
      pump  <= 1'b0;
      busy  <= 1'b0;
      fault <= '0;
    end else begin
      fault <= fault_nxt;
      case (state)
        IDLE: begin
          if (en && sample) begin
            state <= CHECK;
            zone  <= '0;
            busy  <= 1'b1;
          end
        end
        CHECK: begin
          if (!en) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (!fault[zone] && dry) begin
            state <= SETTLE_S;
            cnt   <= '0;
            valve <= zone_oh;
          end else if (last) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            zone <= zone + 1'b1;
          end
        end
        SETTLE_S: begin
          if (!en) begin
            state <= DRAIN;
            stop  <= 1'b1;
          end else if (cnt == CW'(SETTLE-1)) begin
            state <= WATER;
            cnt   <= '0;
            pump  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WATER: begin
          if (!en) begin
            state <= DRAIN;
            stop  <= 1'b1;
            pump  <= 1'b0;
          end else if (is_wet || timeout) begin
            state <= DRAIN;
            pump  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DRAIN: begin
          valve <= '0;
          stop  <= 1'b0;
          if (stop || last) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= CHECK;
            zone  <= zone + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          valve <= '0;
          pump  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
